// File: rtl/instr_fetch_queue.sv
// In-order instruction prefetch queue with redirect flush and drain of in-flight responses.
// Optional macro IFQ_BYPASS_EN presents a response on the head outputs in the cycle it arrives.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_V = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic        in_fetch_s;
    logic        rsp_ok_s;
    logic        grant_s;
    logic        byp_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] outst_ext_s;
    logic [31:0] rsp_pc_s;

    // Requests in flight were issued back-to-back from fetch_pc, so the oldest one's address is recoverable.
    assign in_fetch_s  = (state_q == FETCH);
    assign rsp_ok_s    = imem_rvalid && (outst_q != CNT_ZERO);
    assign outst_ext_s = 32'(outst_q);
    assign rsp_pc_s    = fetch_pc_q - {outst_ext_s[29:0], 2'b00};
    assign imem_req    = reset && in_fetch_s && !redirect &&
                         (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_V);
    assign imem_addr   = fetch_pc_q;
    assign grant_s     = imem_req && imem_gnt;

`ifdef IFQ_BYPASS_EN
    assign byp_s = in_fetch_s && (count_q == CNT_ZERO) && !redirect && rsp_ok_s;
`else
    assign byp_s = 1'b0;
`endif

    assign pop_s  = in_fetch_s && !redirect && (count_q != CNT_ZERO) && instr_ready;
    assign push_s = in_fetch_s && !redirect && rsp_ok_s && !(byp_s && instr_ready);

    // Head outputs: queued entry first, otherwise the bypassed response, otherwise zero.
    always_comb begin
        instr_valid = 1'b0;
        instr       = 32'h0000_0000;
        instr_pc    = 32'h0000_0000;
        if (count_q != CNT_ZERO) begin
            instr_valid = 1'b1;
            instr       = mem_instr_q[head_q];
            instr_pc    = mem_pc_q[head_q];
        end else if (byp_s) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = rsp_pc_s;
        end else begin
            instr_valid = 1'b0;
        end
    end

    // Next-state logic for FSM, fetch PC, occupancy and pointers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        case ({grant_s, rsp_ok_s})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
        if (redirect) begin
            count_d    = CNT_ZERO;
            head_d     = PTR_ZERO;
            tail_d     = PTR_ZERO;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            state_d    = (outst_d != CNT_ZERO) ? DRAIN : FETCH;
        end else if (state_q == DRAIN) begin
            state_d = (outst_d == CNT_ZERO) ? FETCH : DRAIN;
        end else begin
            if (grant_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State and queue storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= CNT_ZERO;
            outst_q    <= CNT_ZERO;
            head_q     <= PTR_ZERO;
            tail_q     <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0000_0000;
                mem_pc_q[i]    <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push_s) begin
                mem_instr_q[tail_q] <= imem_rdata;
                mem_pc_q[tail_q]    <= rsp_pc_s;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-level reference model, plus directed scenarios.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } fl_t;

    ent_t        q[$];
    fl_t         inflight[$];
    logic [31:0] fetch_pc;
    bit          draining;
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    int          p_gnt, p_rv, p_rdy, p_spur, lat_max;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [31:0] pop_pc[$], pop_data[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hE3A0_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        inflight.delete();
        fetch_pc = RESET_PC;
        draining = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        model_reset();
        repeat (2) begin
            #3;
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_pc", instr_pc, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model at the edge.
    task automatic cycle(input bit rd, input logic [31:0] rpc);
        bit          ereq, rsp, bp, ev, take;
        logic [31:0] ei, ep;
        fl_t         f;
        ent_t        e;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = ($urandom_range(99) < p_gnt);
        instr_ready = ($urandom_range(99) < p_rdy);
        if (inflight.size() > 0 && inflight[0].due <= cyc && $urandom_range(99) < p_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(inflight[0].addr);
        end else if (inflight.size() == 0 && $urandom_range(99) < p_spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #3;
        ereq = !draining && !rd && ((q.size() + inflight.size()) < DEPTH);
        rsp  = imem_rvalid && (inflight.size() > 0);
        bp   = BYP && !draining && !rd && (q.size() == 0) && rsp;
        if (q.size() > 0) begin
            ev = 1'b1; ei = q[0].data; ep = q[0].addr;
        end else if (bp) begin
            ev = 1'b1; ei = imem_rdata; ep = inflight[0].addr;
        end else begin
            ev = 1'b0; ei = 32'd0; ep = 32'd0;
        end
        chk("req", 32'(imem_req), 32'(ereq));
        chk("addr", imem_addr, fetch_pc);
        chk("valid", 32'(instr_valid), 32'(ev));
        chk("instr", instr, ei);
        chk("pc", instr_pc, ep);
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_instr = instr; s_pc = instr_pc;
        if (instr_valid && instr_ready && !rd) begin
            pop_pc.push_back(instr_pc);
            pop_data.push_back(instr);
        end
        @(posedge clk);
        if (rd) begin
            q.delete();
            if (rsp) void'(inflight.pop_front());
            fetch_pc = {rpc[31:2], 2'b00};
            draining = (inflight.size() != 0);
        end else if (draining) begin
            if (rsp) void'(inflight.pop_front());
            if (inflight.size() == 0) draining = 1'b0;
        end else begin
            take = bp && instr_ready;
            if (q.size() > 0 && instr_ready) void'(q.pop_front());
            if (rsp) begin
                f = inflight.pop_front();
                e.addr = f.addr;
                e.data = imem_rdata;
                if (!take) q.push_back(e);
            end
            if (ereq && imem_gnt) begin
                f.addr = fetch_pc;
                f.due  = cyc + int'($urandom_range(lat_max, 1));
                inflight.push_back(f);
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int sp, input int lm);
        p_gnt = g; p_rv = rv; p_rdy = rdy; p_spur = sp; lat_max = lm;
    endtask

    initial begin
        int grants;
        bit found;
        #1;
        // Sequential fetch after reset with 1-cycle responses.
        set_knobs(100, 100, 100, 0, 1);
        reset_dut();
        pop_pc.delete(); pop_data.delete();
        cycle(1'b0, 32'd0);
        chk("t1_req0", 32'(s_req), 32'd1);
        chk("t1_addr0", s_addr, 32'h0);
        cycle(1'b0, 32'd0);
        chk("t1_addr1", s_addr, 32'h4);
        chk("t1_byp_valid", 32'(s_valid), 32'(BYP));
        cycle(1'b0, 32'd0);
        chk("t1_addr2", s_addr, 32'h8);
        chk("t1_c2_valid", 32'(s_valid), 32'd1);
        chk("t1_c2_instr", s_instr, BYP ? 32'hE3A0_0005 : 32'hE3A0_0001);
        repeat (4) cycle(1'b0, 32'd0);
        if (pop_pc.size() >= 3) begin
            chk("t1_pop_pc0", pop_pc[0], 32'h0);
            chk("t1_pop_pc1", pop_pc[1], 32'h4);
            chk("t1_pop_pc2", pop_pc[2], 32'h8);
            chk("t1_pop_d0", pop_data[0], 32'hE3A0_0001);
            chk("t1_pop_d2", pop_data[2], 32'hE3A0_0009);
        end else begin
            chk("t1_pop_count", 32'(pop_pc.size()), 32'd3);
        end

        // Fill with the consumer stalled, then drain one entry per cycle.
        set_knobs(100, 100, 0, 0, 1);
        reset_dut();
        grants = 0;
        repeat (8) begin
            cycle(1'b0, 32'd0);
            if (s_req && imem_gnt) grants++;
        end
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req_off", 32'(s_req), 32'd0);
        chk("t2_valid", 32'(s_valid), 32'd1);
        p_rdy = 100;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0);
            chk("t2_pop_valid", 32'(s_valid), 32'd1);
            chk("t2_pop_pc", s_pc, 32'(4 * i));
        end

        // Redirect with two requests outstanding.
        set_knobs(100, 0, 100, 0, 1);
        reset_dut();
        cycle(1'b0, 32'd0);
        cycle(1'b0, 32'd0);
        cycle(1'b1, 32'h0000_1003);
        chk("t3_redir_req", 32'(s_req), 32'd0);
        p_rv = 100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'd0);
            if (s_req) begin
                found = 1'b1;
                chk("t3_new_addr", s_addr, 32'h0000_1000);
            end
        end
        if (!found) chk("t3_req_timeout", 32'd0, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'd0);
            if (s_valid) begin
                found = 1'b1;
                chk("t3_first_pc", s_pc, 32'h0000_1000);
            end
        end
        if (!found) chk("t3_valid_timeout", 32'd0, 32'd1);

        // Redirect coinciding with a response and a ready consumer.
        set_knobs(100, 100, 100, 0, 1);
        reset_dut();
        repeat (6) cycle(1'b0, 32'd0);
        cycle(1'b1, 32'h0000_0200);
        chk("t4_rvalid_seen", 32'(imem_rvalid), 32'd1);
        chk("t4_valid_before", 32'(s_valid), 32'd1);
        cycle(1'b0, 32'd0);
        chk("t4_valid_after", 32'(s_valid), 32'd0);

        // Address wrap at the top of the address space.
        set_knobs(100, 100, 0, 0, 1);
        reset_dut();
        cycle(1'b1, 32'hFFFF_FFFE);
        cycle(1'b0, 32'd0);
        chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        chk("t5_req_top", 32'(s_req), 32'd1);
        cycle(1'b0, 32'd0);
        chk("t5_addr_wrap", s_addr, 32'h0000_0000);

        // Randomized traffic with redirects, spurious responses and occasional resets.
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                set_knobs($urandom_range(100, 20), $urandom_range(100, 30), $urandom_range(100, 0),
                          $urandom_range(10, 0), $urandom_range(4, 1));
            end
            if ($urandom_range(999) < 3) begin
                reset_dut();
            end else begin
                cycle($urandom_range(99) < 4, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
